// File: rtl/dae_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dae_pkg
// Purpose  : Opcode constants and the shared ALU function for the
//            decode/execute pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package dae_pkg;

    // Widest datapath the ALU function handles; instances narrow it by width.
    localparam int MAXW = 64;

    localparam logic [2:0] OP_SUB = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_ASR = 3'd4;
    localparam logic [2:0] OP_ROL = 3'd5;
    localparam logic [2:0] OP_SLT = 3'd6;
    localparam logic [2:0] OP_SEQ = 3'd7;

    // Evaluates one opcode at width w (4..MAXW). Operands arrive zero-extended
    // to MAXW bits; the result is masked to w bits so callers can truncate.
    function automatic logic [MAXW-1:0] alu(
        input logic [2:0]      sel,
        input logic [MAXW-1:0] rs,
        input logic [MAXW-1:0] rt,
        input int              w
    );
        logic [MAXW-1:0] c_one;
        logic [MAXW-1:0] mask;
        logic [MAXW-1:0] y;
        c_one = {{(MAXW-1){1'b0}}, 1'b1};
        mask  = (w >= MAXW) ? {MAXW{1'b1}} : ((c_one << w) - c_one);
        case (sel)
            OP_SUB:  y = rs - rt;
            OP_ADD:  y = rs + rt;
            OP_OR:   y = rs | rt;
            OP_AND:  y = rs & rt;
            // Sign bit of rt is replicated into the vacated top position.
            OP_ASR:  y = (rt >> 1) | (((rt >> (w - 1)) & c_one) << (w - 1));
            OP_ROL:  y = (rs << 1) | ((rs >> (w - 1)) & c_one);
            // Pattern 10_11..1_x: clear bit w-2 and bit 0, then insert flag.
            OP_SLT:  y = (mask & ~(c_one << (w - 2)) & ~c_one)
                         | ((rs < rt) ? c_one : {MAXW{1'b0}});
            OP_SEQ:  y = (mask & ~c_one)
                         | ((rs == rt) ? c_one : {MAXW{1'b0}});
            default: y = {MAXW{1'b0}};
        endcase
        return y & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dae_if.sv
`default_nettype none
// ============================================================================
// Module   : dae_if
// Purpose  : Instruction-in / result-out handshake bundle for
//            decode_execute_pipe.
// Revision : 1.0 - initial release
// ============================================================================
interface dae_if #(
    parameter int WIDTH = 4,
    parameter int NREG  = 4
);
    localparam int RW = $clog2(NREG);

    logic             in_valid;
    logic             in_ready;
    logic             in_ld;
    logic [2:0]       in_sel;
    logic [RW-1:0]    in_rs;
    logic [RW-1:0]    in_rt;
    logic [RW-1:0]    in_rd;
    logic [WIDTH-1:0] in_imm;

    logic             out_valid;
    logic             out_ready;
    logic [RW-1:0]    out_rd;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;

    // Instruction source and result consumer side.
    modport master (
        output in_valid, in_ld, in_sel, in_rs, in_rt, in_rd, in_imm, out_ready,
        input  in_ready, out_valid, out_rd, out_data, out_zero
    );

    // Pipeline side.
    modport slave (
        input  in_valid, in_ld, in_sel, in_rs, in_rt, in_rd, in_imm, out_ready,
        output in_ready, out_valid, out_rd, out_data, out_zero
    );
endinterface
`default_nettype wire

// File: rtl/dae_alu.sv
`default_nettype none
// ============================================================================
// Module   : dae_alu
// Purpose  : Combinational eight-operation ALU at WIDTH bits.
// Revision : 1.0 - initial release
// ============================================================================
module dae_alu
    import dae_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  wire logic [2:0]       sel,
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    output logic      [WIDTH-1:0] y
);

    // Widen, evaluate at WIDTH, then narrow back (upper bits are already 0).
    assign y = WIDTH'(alu(sel, MAXW'(a), MAXW'(b), WIDTH));

endmodule
`default_nettype wire

// File: rtl/decode_execute_pipe.sv
`default_nettype none
// ============================================================================
// Module   : decode_execute_pipe
// Purpose  : Two-stage decode/execute pipeline with an NREG-entry register
//            file, immediate loads and valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module decode_execute_pipe
    import dae_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NREG  = 4,
    parameter int RW    = $clog2(NREG)
) (
    input  wire logic clk,
    input  wire logic rst,
    dae_if.slave      bus
);

    // Stage 1: captured instruction
    logic             r_s1_valid;
    logic             r_s1_ld;
    logic [2:0]       r_s1_sel;
    logic [RW-1:0]    r_s1_rs;
    logic [RW-1:0]    r_s1_rt;
    logic [RW-1:0]    r_s1_rd;
    logic [WIDTH-1:0] r_s1_imm;

    // Stage 2: output register
    logic             r_out_valid;
    logic [RW-1:0]    r_out_rd;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_zero;

    logic [WIDTH-1:0] r_regs [NREG];

    logic             w_advance;
    logic             w_in_ready;
    logic             w_fire;
    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_opb;
    logic [WIDTH-1:0] w_alu_y;
    logic [WIDTH-1:0] w_result;

    // S2 can take new data whenever it is empty or being drained this cycle.
    assign w_advance  = !r_out_valid || bus.out_ready;
    assign w_in_ready = !r_s1_valid || w_advance;
    assign w_fire     = r_s1_valid && w_advance;

    // Operand fetch happens in S1; the write-back of the instruction ahead
    // lands on the same edge it leaves S1, so no forwarding path is needed.
    assign w_opa = r_regs[r_s1_rs];
    assign w_opb = r_regs[r_s1_rt];

    dae_alu #(.WIDTH(WIDTH)) u_alu (
        .sel (r_s1_sel),
        .a   (w_opa),
        .b   (w_opb),
        .y   (w_alu_y)
    );

    assign w_result = r_s1_ld ? r_s1_imm : w_alu_y;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_rd    = r_out_rd;
    assign bus.out_data  = r_out_data;
    assign bus.out_zero  = r_out_zero;

    // S1 load: refill (or empty) whenever the slot is free or moving on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_ld    <= 1'b0;
            r_s1_sel   <= 3'd0;
            r_s1_rs    <= '0;
            r_s1_rt    <= '0;
            r_s1_rd    <= '0;
            r_s1_imm   <= '0;
        end else if (w_in_ready) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_ld  <= bus.in_ld;
                r_s1_sel <= bus.in_sel;
                r_s1_rs  <= bus.in_rs;
                r_s1_rt  <= bus.in_rt;
                r_s1_rd  <= bus.in_rd;
                r_s1_imm <= bus.in_imm;
            end
        end
    end

    // S2 load: take the S1 result, or go empty if S1 has nothing behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_rd    <= '0;
            r_out_data  <= '0;
            r_out_zero  <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_rd   <= r_s1_rd;
                r_out_data <= w_result;
                r_out_zero <= (w_result == '0);
            end
        end
    end

    // Register-file write-back, committed as the instruction enters S2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_fire) begin
            r_regs[r_s1_rd] <= w_result;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_execute_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_execute_pipe
// Purpose  : Self-checking bench for decode_execute_pipe at W=4/NREG=4 and
//            W=8/NREG=8, with a reference model of the instruction set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_execute_pipe;

    typedef struct {
        int rd;
        int data;
        int zero;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dae_if #(.WIDTH(4), .NREG(4)) b4 ();
    dae_if #(.WIDTH(8), .NREG(8)) b8 ();

    decode_execute_pipe #(.WIDTH(4), .NREG(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    decode_execute_pipe #(.WIDTH(8), .NREG(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));

    int   m4 [4];
    int   m8 [8];
    res_t exp4 [$];
    res_t got4 [$];
    res_t exp8 [$];
    res_t got8 [$];

    // Instruction semantics in plain modular arithmetic.
    function automatic int ref_op(int ld, int sel, int a, int b, int imm, int w);
        int m;
        m = 1 << w;
        if (ld != 0) return imm % m;
        case (sel)
            0: return (a - b + m) % m;
            1: return (a + b) % m;
            2: return a | b;
            3: return a & b;
            4: return (b / 2) + ((b >= m / 2) ? m / 2 : 0);
            5: return ((a * 2) % m) + ((a >= m / 2) ? 1 : 0);
            6: return (m - 1) - (m / 4) - 1 + ((a < b) ? 1 : 0);
            default: return (m - 2) + ((a == b) ? 1 : 0);
        endcase
    endfunction

    // Observe handshakes mid-cycle: anything valid&ready now transfers at the
    // next rising edge. Accepted instructions update the model in order.
    always @(negedge clk) begin
        if (!rst) begin
            int v;
            if (b4.out_valid && b4.out_ready)
                got4.push_back('{rd: int'(b4.out_rd), data: int'(b4.out_data), zero: int'(b4.out_zero)});
            if (b4.in_valid && b4.in_ready) begin
                v = ref_op(int'(b4.in_ld), int'(b4.in_sel), m4[int'(b4.in_rs)], m4[int'(b4.in_rt)], int'(b4.in_imm), 4);
                m4[int'(b4.in_rd)] = v;
                exp4.push_back('{rd: int'(b4.in_rd), data: v, zero: (v == 0) ? 1 : 0});
            end
            if (b8.out_valid && b8.out_ready)
                got8.push_back('{rd: int'(b8.out_rd), data: int'(b8.out_data), zero: int'(b8.out_zero)});
            if (b8.in_valid && b8.in_ready) begin
                v = ref_op(int'(b8.in_ld), int'(b8.in_sel), m8[int'(b8.in_rs)], m8[int'(b8.in_rt)], int'(b8.in_imm), 8);
                m8[int'(b8.in_rd)] = v;
                exp8.push_back('{rd: int'(b8.in_rd), data: v, zero: (v == 0) ? 1 : 0});
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 4; i++) m4[i] = 0;
        for (int i = 0; i < 8; i++) m8[i] = 0;
        exp4.delete(); got4.delete(); exp8.delete(); got8.delete();
    endtask

    // Present one instruction and hold it until it is taken (bounded).
    task automatic issue4(input int ld, input int sel, input int rs, input int rt, input int rd, input int imm);
        int k;
        b4.in_valid = 1'b1;
        b4.in_ld    = ld[0];
        b4.in_sel   = 3'(sel);
        b4.in_rs    = 2'(rs);
        b4.in_rt    = 2'(rt);
        b4.in_rd    = 2'(rd);
        b4.in_imm   = 4'(imm);
        k = 0;
        @(negedge clk);
        while (!b4.in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!b4.in_ready) begin
            errors++;
            $display("FAIL issue4_timeout: in_ready=%0b required=1 after %0d cycles", b4.in_ready, k);
        end
        @(posedge clk); #1;
    endtask

    task automatic issue8(input int ld, input int sel, input int rs, input int rt, input int rd, input int imm);
        int k;
        b8.in_valid = 1'b1;
        b8.in_ld    = ld[0];
        b8.in_sel   = 3'(sel);
        b8.in_rs    = 3'(rs);
        b8.in_rt    = 3'(rt);
        b8.in_rd    = 3'(rd);
        b8.in_imm   = 8'(imm);
        k = 0;
        @(negedge clk);
        while (!b8.in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!b8.in_ready) begin
            errors++;
            $display("FAIL issue8_timeout: in_ready=%0b required=1 after %0d cycles", b8.in_ready, k);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle4();
        b4.in_valid = 1'b0;
    endtask

    task automatic idle8();
        b8.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        b4.in_valid = 0; b4.in_ld = 0; b4.in_sel = 0; b4.in_rs = 0; b4.in_rt = 0;
        b4.in_rd = 0; b4.in_imm = 0; b4.out_ready = 1;
        b8.in_valid = 0; b8.in_ld = 0; b8.in_sel = 0; b8.in_rs = 0; b8.in_rt = 0;
        b8.in_rd = 0; b8.in_imm = 0; b8.out_ready = 1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        #1;
        checks += 5;
        if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", b4.out_valid); end
        if (b4.out_data !== 4'h0)  begin errors++; $display("FAIL reset_out_data: got %0h want 0", b4.out_data); end
        if (b4.out_rd !== 2'd0)    begin errors++; $display("FAIL reset_out_rd: got %0d want 0", b4.out_rd); end
        if (b4.out_zero !== 1'b0)  begin errors++; $display("FAIL reset_out_zero: got %0b want 0", b4.out_zero); end
        if (b4.in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %0b want 1", b4.in_ready); end
        checks += 2;
        if (b8.out_valid !== 1'b0) begin errors++; $display("FAIL reset8_out_valid: got %0b want 0", b8.out_valid); end
        if (b8.in_ready !== 1'b1)  begin errors++; $display("FAIL reset8_in_ready: got %0b want 1", b8.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic_latency();
        b4.out_ready = 1;
        issue4(1, 0, 0, 0, 1, 5);
        checks++;
        if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL lat_early: out_valid=%0b want 0", b4.out_valid); end
        issue4(1, 0, 0, 0, 2, 3);
        checks += 2;
        if (b4.out_valid !== 1'b1) begin errors++; $display("FAIL lat_first_valid: out_valid=%0b want 1", b4.out_valid); end
        if (b4.out_data !== 4'd5)  begin errors++; $display("FAIL b2b_0: out_data=%0d want 5", b4.out_data); end
        issue4(0, 0, 1, 2, 3, 0);
        checks++;
        if (b4.out_data !== 4'd3)  begin errors++; $display("FAIL b2b_1: out_data=%0d want 3", b4.out_data); end
        idle4();
        @(posedge clk); #1;
        checks += 3;
        if (b4.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_2_valid: out_valid=%0b want 1", b4.out_valid); end
        if (b4.out_data !== 4'd2)  begin errors++; $display("FAIL b2b_2: out_data=%0d want 2", b4.out_data); end
        if (b4.out_rd !== 2'd3)    begin errors++; $display("FAIL b2b_2_rd: out_rd=%0d want 3", b4.out_rd); end
        @(posedge clk); #1;
        checks++;
        if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: out_valid=%0b want 0", b4.out_valid); end
    endtask

    task automatic test_dependency();
        got4.delete(); exp4.delete();
        b4.out_ready = 1;
        issue4(1, 0, 0, 0, 1, 7);
        checks++;
        if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL dep_ready0: in_ready=%0b want 1", b4.in_ready); end
        issue4(0, 1, 1, 1, 2, 0);
        checks++;
        if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL dep_ready1: in_ready=%0b want 1", b4.in_ready); end
        idle4();
        for (int k = 0; k < 20 && got4.size() < 2; k++) @(posedge clk);
        #1;
        checks++;
        if (got4.size() != 2) begin
            errors++; $display("FAIL dep_count: got %0d results want 2", got4.size());
        end else begin
            checks++;
            if (got4[1].data != 14 || got4[1].rd != 2)
                begin errors++; $display("FAIL dep_add: data=%0d rd=%0d want 14 rd 2", got4[1].data, got4[1].rd); end
        end
    endtask

    task automatic test_edge_ops();
        // ld, sel, rs, rt, rd, imm, expected result
        int tab [17][7] = '{
            '{1,0,0,0,1, 8, 8}, '{0,4,0,1,2,0,12}, '{0,5,1,0,2,0, 1},
            '{1,0,0,0,1, 3, 3}, '{1,0,0,0,2,5, 5}, '{0,6,1,2,3,0,11},
            '{0,6,2,1,3, 0,10}, '{1,0,0,0,1,5, 5}, '{0,7,1,2,3,0,15},
            '{1,0,0,0,2, 6, 6}, '{0,7,1,2,3,0,14}, '{1,0,0,0,1,0, 0},
            '{1,0,0,0,2, 1, 1}, '{0,0,1,2,3,0,15}, '{1,0,0,0,1,10,10},
            '{1,0,0,0,2, 5, 5}, '{0,3,1,2,0,0, 0}
        };
        got4.delete(); exp4.delete();
        b4.out_ready = 1;
        for (int i = 0; i < 17; i++) issue4(tab[i][0], tab[i][1], tab[i][2], tab[i][3], tab[i][4], tab[i][5]);
        idle4();
        for (int k = 0; k < 30 && got4.size() < 17; k++) @(posedge clk);
        #1;
        checks++;
        if (got4.size() != 17) begin
            errors++; $display("FAIL edge_count: got %0d results want 17", got4.size());
        end else begin
            for (int i = 0; i < 17; i++) begin
                checks++;
                if (got4[i].data != tab[i][6] || got4[i].rd != tab[i][4] || got4[i].zero != ((tab[i][6] == 0) ? 1 : 0))
                    begin errors++; $display("FAIL edge_op_%0d: data=%0d rd=%0d zero=%0d want data=%0d rd=%0d",
                                             i, got4[i].data, got4[i].rd, got4[i].zero, tab[i][6], tab[i][4]); end
            end
        end
    endtask

    task automatic test_backpressure();
        int want [4] = '{1, 2, 3, 1};
        got4.delete(); exp4.delete();
        b4.out_ready = 0;
        fork
            begin
                issue4(1, 0, 0, 0, 0, 1);
                issue4(1, 0, 0, 0, 1, 2);
                issue4(0, 1, 0, 1, 2, 0);
                issue4(0, 0, 1, 0, 3, 0);
                idle4();
            end
            begin
                repeat (4) @(posedge clk);
                #2;
                checks += 3;
                if (b4.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: in_ready=%0b want 0", b4.in_ready); end
                if (exp4.size() != 2)     begin errors++; $display("FAIL bp_accepts: accepted=%0d want 2", exp4.size()); end
                if (got4.size() != 0)     begin errors++; $display("FAIL bp_leak: consumed=%0d want 0", got4.size()); end
                b4.out_ready = 1;
            end
        join
        for (int k = 0; k < 20 && got4.size() < 4; k++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (got4.size() != 4) begin
            errors++; $display("FAIL bp_count: got %0d results want 4", got4.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got4[i].data != want[i] || got4[i].rd != i)
                    begin errors++; $display("FAIL bp_order_%0d: data=%0d rd=%0d want %0d rd %0d", i, got4[i].data, got4[i].rd, want[i], i); end
            end
        end
    endtask

    task automatic test_reset_midstream();
        b4.out_ready = 0;
        issue4(1, 0, 0, 0, 1, 5);
        issue4(1, 0, 0, 0, 2, 3);
        idle4();
        #2;
        rst = 1'b1;
        #1;
        checks += 2;
        if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: out_valid=%0b want 0", b4.out_valid); end
        if (b4.in_ready !== 1'b1)  begin errors++; $display("FAIL rstmid_ready: in_ready=%0b want 1", b4.in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        b4.out_ready = 1;
        issue4(0, 1, 1, 2, 0, 0);
        idle4();
        for (int k = 0; k < 20 && got4.size() < 1; k++) @(posedge clk);
        #1;
        checks++;
        if (got4.size() != 1) begin
            errors++; $display("FAIL rstmid_count: got %0d results want 1", got4.size());
        end else begin
            checks++;
            if (got4[0].data != 0 || got4[0].zero != 1)
                begin errors++; $display("FAIL rstmid_add: data=%0d zero=%0d want 0 zero 1", got4[0].data, got4[0].zero); end
        end
    endtask

    task automatic test_random();
        bit done = 0;
        got4.delete(); exp4.delete();
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    issue4(($urandom % 4 == 0) ? 1 : 0, int'($urandom % 8), int'($urandom % 4),
                           int'($urandom % 4), int'($urandom % 4), int'($urandom % 16));
                    if ($urandom % 4 == 0) begin
                        idle4();
                        @(posedge clk); #1;
                    end
                end
                idle4();
                done = 1;
            end
            begin
                while (!done) begin
                    b4.out_ready = ($urandom % 3 != 0);
                    @(posedge clk); #1;
                end
                b4.out_ready = 1;
            end
        join
        for (int k = 0; k < 40 && got4.size() < exp4.size(); k++) @(posedge clk);
        #1;
        checks++;
        if (got4.size() != exp4.size() || exp4.size() != 60) begin
            errors++; $display("FAIL rand_count: got %0d results, model %0d, want 60", got4.size(), exp4.size());
        end else begin
            for (int i = 0; i < 60; i++) begin
                checks++;
                if (got4[i].data != exp4[i].data || got4[i].rd != exp4[i].rd || got4[i].zero != exp4[i].zero)
                    begin errors++; $display("FAIL rand_%0d: data=%0d rd=%0d zero=%0d want data=%0d rd=%0d zero=%0d", i,
                                             got4[i].data, got4[i].rd, got4[i].zero, exp4[i].data, exp4[i].rd, exp4[i].zero); end
            end
        end
    endtask

    task automatic test_width8();
        // ld, sel, rs, rt, rd, imm, expected result
        int tab [11][7] = '{
            '{1,0,0,0,1,200,200}, '{1,0,0,0,2,100,100}, '{0,1,1,2,3,0,44},
            '{1,0,0,0,1,  3,  3}, '{1,0,0,0,2,  5,  5}, '{0,6,1,2,3,0,191},
            '{1,0,0,0,4,  9,  9}, '{1,0,0,0,5,  9,  9}, '{0,7,4,5,6,0,255},
            '{1,0,0,0,7,129,129}, '{0,5,7,0,0,  0,  3}
        };
        got8.delete(); exp8.delete();
        b8.out_ready = 1;
        for (int i = 0; i < 11; i++) issue8(tab[i][0], tab[i][1], tab[i][2], tab[i][3], tab[i][4], tab[i][5]);
        idle8();
        for (int k = 0; k < 20 && got8.size() < 11; k++) @(posedge clk);
        #1;
        checks++;
        if (got8.size() != 11) begin
            errors++; $display("FAIL w8_count: got %0d results want 11", got8.size());
        end else begin
            for (int i = 0; i < 11; i++) begin
                checks++;
                if (got8[i].data != tab[i][6] || got8[i].rd != tab[i][4] || got8[i].data != exp8[i].data)
                    begin errors++; $display("FAIL w8_op_%0d: data=%0d rd=%0d want data=%0d rd=%0d (model %0d)",
                                             i, got8[i].data, got8[i].rd, tab[i][6], tab[i][4], exp8[i].data); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_dependency();
        test_edge_ops();
        test_backpressure();
        test_reset_midstream();
        test_random();
        test_width8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
